// File: rtl/cfs_apb_master_pkg.sv
// ============================================================================
// Module   : cfs_apb_master_pkg
// Brief    : Shared state encoding and sizing helper for the APB requester.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cfs_apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    // Wide enough to hold TIMEOUT_CYCLES-1; never narrower than one bit.
    function automatic int unsigned wait_cnt_width(input int unsigned timeout_cycles);
        return (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfs_apb_timeout_cnt.sv
// ============================================================================
// Module   : cfs_apb_timeout_cnt
// Brief    : ACCESS wait counter with expiry flag and saturating abort count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfs_apb_timeout_cnt
    import cfs_apb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 tick,
    input  logic                 fire,
    output logic                 expired,
    output logic [CNT_WIDTH-1:0] cnt_timeout
);

    localparam int unsigned c_wait_w = wait_cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned c_last   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    logic [c_wait_w-1:0] r_wait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
        end else if (clr) begin
            r_wait <= '0;
        end else if (tick) begin
            r_wait <= r_wait + c_wait_w'(1);
        end
    end

    // A zero timeout disables expiry; the counter then just wraps harmlessly.
    assign expired = (TIMEOUT_CYCLES != 0) && (r_wait == c_wait_w'(c_last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_timeout <= '0;
        end else if (fire && (cnt_timeout != {CNT_WIDTH{1'b1}})) begin
            cnt_timeout <= cnt_timeout + CNT_WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/cfs_apb_master.sv
// ============================================================================
// Module   : cfs_apb_master
// Brief    : APB3 requester driven by a valid/ready command/response stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfs_apb_master
    import cfs_apb_master_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 16,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    output logic [APB_DATA_WIDTH-1:0] pwdata,
    input  logic [APB_DATA_WIDTH-1:0] prdata,
    input  logic                      pready,
    input  logic                      pslverr,
    output logic [CNT_WIDTH-1:0]      cnt_timeout
);

    apb_state_t r_state;
    apb_state_t w_state_nxt;
    logic       w_accept;
    logic       w_expired;
    logic       w_timeout;

    assign w_accept  = (r_state == ST_IDLE) && cmd_valid && cmd_ready;
    assign w_timeout = (r_state == ST_ACCESS) && !pready && w_expired;

    cfs_apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_timeout_cnt (
        .clk         (clk),
        .rst         (reset),
        .clr         (r_state == ST_SETUP),
        .tick        ((r_state == ST_ACCESS) && !pready),
        .fire        (w_timeout),
        .expired     (w_expired),
        .cnt_timeout (cnt_timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)              w_state_nxt = ST_SETUP;
            ST_SETUP:                             w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (pready || w_expired)   w_state_nxt = ST_RESP;
            ST_RESP:   if (rsp_ready)             w_state_nxt = ST_IDLE;
            default:                              w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake and bus strobes are registered from the next state so every
    // output comes straight off a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            cmd_ready <= (w_state_nxt == ST_IDLE);
            rsp_valid <= (w_state_nxt == ST_RESP);
            psel      <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
            penable   <= (w_state_nxt == ST_ACCESS);
            if (w_accept) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
            end
            if (r_state == ST_ACCESS) begin
                if (pready) begin
                    rsp_rdata   <= pwrite ? '0 : prdata;
                    rsp_err     <= pslverr;
                    rsp_timeout <= 1'b0;
                end else if (w_expired) begin
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
